// File: rtl/audio_out_scheduler_if.sv
// Sample-side and sender-side handshake signals of the audio output scheduler.
// The master modport is the scheduler; slave is its NeXT/I2S environment.
interface audio_out_scheduler_if;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        dma_req;
  logic        i2s_req;
  logic        i2s_valid;
  logic [31:0] i2s_data;
  logic        i2s_start;

  modport master (
    input  sample_valid, sample_data, i2s_req,
    output dma_req, i2s_valid, i2s_data, i2s_start
  );

  modport slave (
    output sample_valid, sample_data, i2s_req,
    input  dma_req, i2s_valid, i2s_data, i2s_start
  );
endinterface

// File: rtl/audio_out_scheduler.sv
// Playback sequencer between the NeXT sound-out channel and the I2S sender:
// requests sample blocks, buffers them in a FIFO and serves one per sender request.
module audio_out_scheduler #(
  parameter int DEPTH_LOG2  = 4,
  parameter int BLOCK       = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                  in_clk,
  input  logic                  reset_n,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  audio_out_scheduler_if.master bus,
  output logic                  busy,
  output logic                  underrun,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int RXW      = (BLOCK > 1) ? $clog2(BLOCK) : 1;
  localparam int BLOCK_M1 = BLOCK - 1;

  localparam logic [DEPTH_LOG2:0]   DEPTH_L = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   BLOCK_L = BLOCK[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   PRIME_L = PRIME_LEVEL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [RXW-1:0]        LAST_RX = BLOCK_M1[RXW-1:0];
  localparam logic [RXW-1:0]        RX_ONE  = {{(RXW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  outstanding_q;
  logic [RXW-1:0]        rx_count_q;
  logic                  dma_req_q, dma_req_d;
  logic                  i2s_valid_q, i2s_valid_d;
  logic                  i2s_start_q, i2s_start_d;
  logic [31:0]           i2s_data_q, i2s_data_d;
  logic                  underrun_q, overflow_q;

  logic start_go, accept, full, empty, push, pop, serve, block_done;

  assign start_go   = (state_q == IDLE) && cmd_start && !cmd_stop;
  assign accept     = bus.sample_valid && (state_q != IDLE);
  assign full       = (level_q == DEPTH_L);
  assign empty      = (level_q == '0);
  assign push       = accept && !full;
  assign serve      = bus.i2s_req && ((state_q == RUN) || (state_q == DRAIN));
  assign pop        = serve && !empty;
  // Dropped samples were still delivered by NeXT, so they count toward the block.
  assign block_done = accept && outstanding_q && (rx_count_q == LAST_RX);
  assign i2s_data_d = empty ? 32'h0 : mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_go) state_d = PRIME;
      PRIME: if (cmd_stop) state_d = DRAIN;
             else if (level_q >= PRIME_L) state_d = RUN;
      RUN:   if (cmd_stop) state_d = DRAIN;
      DRAIN: if (empty && !outstanding_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i2s_start_d = (state_q == PRIME) && (state_d == RUN);
    dma_req_d   = ((state_q == PRIME) || (state_q == RUN)) && !outstanding_q &&
                  ((DEPTH_L - level_q) >= BLOCK_L);
    i2s_valid_d = serve;
  end

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      outstanding_q <= 1'b0;
      rx_count_q    <= '0;
      dma_req_q     <= 1'b0;
      i2s_valid_q   <= 1'b0;
      i2s_start_q   <= 1'b0;
      i2s_data_q    <= '0;
      underrun_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      dma_req_q   <= dma_req_d;
      i2s_valid_q <= i2s_valid_d;
      i2s_start_q <= i2s_start_d;
      if (start_go) begin
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        level_q       <= '0;
        outstanding_q <= 1'b0;
        rx_count_q    <= '0;
        underrun_q    <= 1'b0;
        overflow_q    <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        unique case ({push, pop})
          2'b10:   level_q <= level_q + LVL_ONE;
          2'b01:   level_q <= level_q - LVL_ONE;
          default: level_q <= level_q;
        endcase
        if (accept && full) overflow_q <= 1'b1;
        if (serve) begin
          i2s_data_q <= i2s_data_d;
          if (empty) underrun_q <= 1'b1;
        end
        if (dma_req_d)       outstanding_q <= 1'b1;
        else if (block_done) outstanding_q <= 1'b0;
        if (block_done)                      rx_count_q <= '0;
        else if (accept && outstanding_q)    rx_count_q <= rx_count_q + RX_ONE;
      end
    end
  end

  // NOTE: sample storage carries no reset; the pointers and level alone
  // decide which entries are valid, so stale contents are never observed.
  always_ff @(posedge in_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.sample_data;
  end

  assign bus.dma_req   = dma_req_q;
  assign bus.i2s_valid = i2s_valid_q;
  assign bus.i2s_start = i2s_start_q;
  assign bus.i2s_data  = i2s_data_q;
  assign busy          = (state_q != IDLE);
  assign underrun      = underrun_q;
  assign overflow      = overflow_q;
  assign level         = level_q;
endmodule

// File: tb/tb_audio_out_scheduler.sv
// Self-checking bench for audio_out_scheduler: directed scenarios plus random
// traffic, all checked against a queue-based playback model.
module tb_audio_out_scheduler;
  localparam int DEPTH       = 16;
  localparam int BLOCK       = 4;
  localparam int PRIME_LEVEL = 8;

  logic       in_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_start = 1'b0;
  logic       cmd_stop = 1'b0;
  logic       busy, underrun, overflow;
  logic [4:0] level;

  audio_out_scheduler_if bus ();

  audio_out_scheduler #(
    .DEPTH_LOG2 (4),
    .BLOCK      (BLOCK),
    .PRIME_LEVEL(PRIME_LEVEL)
  ) dut (
    .in_clk   (in_clk),
    .reset_n  (reset_n),
    .cmd_start(cmd_start),
    .cmd_stop (cmd_stop),
    .bus      (bus),
    .busy     (busy),
    .underrun (underrun),
    .overflow (overflow),
    .level    (level)
  );

  always #5 in_clk = ~in_clk;

  int checks = 0;
  int errors = 0;

  // Playback model: state name, sample queue, request bookkeeping, sticky flags
  // and the pulses expected right after the current clock edge.
  typedef enum {M_IDLE, M_PRIME, M_RUN, M_DRAIN} m_state_e;
  m_state_e    m_state;
  logic [31:0] m_q[$];
  bit          m_out;
  int          m_rx;
  bit          m_under, m_over;
  bit          e_dma, e_valid, e_start;
  logic [31:0] e_data;

  task automatic model_reset();
    m_state = M_IDLE;
    m_q.delete();
    m_out = 0; m_rx = 0; m_under = 0; m_over = 0;
    e_dma = 0; e_valid = 0; e_start = 0; e_data = 32'h0;
  endtask

  task automatic model_step(input bit start, input bit stop, input bit sv,
                            input logic [31:0] sd, input bit req);
    int size0 = m_q.size();
    bit out0  = m_out;
    e_dma   = (m_state == M_PRIME || m_state == M_RUN) && !out0 && (DEPTH - size0 >= BLOCK);
    e_start = 0;
    e_valid = req && (m_state == M_RUN || m_state == M_DRAIN);
    if (e_valid) begin
      if (size0 > 0) e_data = m_q.pop_front();
      else begin e_data = 32'h0; m_under = 1; end
    end
    if (sv && m_state != M_IDLE) begin
      if (size0 == DEPTH) m_over = 1;
      else m_q.push_back(sd);
      if (out0) begin
        m_rx++;
        if (m_rx == BLOCK) begin m_out = 0; m_rx = 0; end
      end
    end
    if (e_dma) m_out = 1;
    case (m_state)
      M_IDLE:  if (start && !stop) begin
                 m_q.delete(); m_under = 0; m_over = 0; m_rx = 0; m_out = 0;
                 m_state = M_PRIME;
               end
      M_PRIME: if (stop) m_state = M_DRAIN;
               else if (size0 >= PRIME_LEVEL) begin e_start = 1; m_state = M_RUN; end
      M_RUN:   if (stop) m_state = M_DRAIN;
      M_DRAIN: if (size0 == 0 && !out0) m_state = M_IDLE;
      default: m_state = M_IDLE;
    endcase
  endtask

  function automatic logic [42:0] dut_vec();
    return {bus.dma_req, bus.i2s_valid, bus.i2s_start, busy, underrun, overflow, level, bus.i2s_data};
  endfunction

  function automatic logic [42:0] exp_vec();
    logic [4:0] lv = 5'(m_q.size());
    return {e_dma, e_valid, e_start, (m_state != M_IDLE), m_under, m_over, lv, e_data};
  endfunction

  // Drive at the falling edge, update the model at the rising edge, return at
  // the next falling edge where outputs are sampled.
  task automatic cycle(input bit start, input bit stop, input bit sv,
                       input logic [31:0] sd, input bit req);
    cmd_start = start; cmd_stop = stop;
    bus.sample_valid = sv; bus.sample_data = sd; bus.i2s_req = req;
    @(posedge in_clk);
    model_step(start, stop, sv, sd, req);
    #1;
    cmd_start = 1'b0; cmd_stop = 1'b0; bus.sample_valid = 1'b0; bus.i2s_req = 1'b0;
    @(negedge in_clk);
  endtask

  task automatic idle();                   cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); endtask
  task automatic feed(input logic [31:0] d); cycle(1'b0, 1'b0, 1'b1, d, 1'b0);    endtask
  task automatic request();                cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); endtask
  task automatic do_start();               cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge in_clk);
    checks++;
    if (dut_vec() !== 43'h0) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_vec(), 43'h0);
    end
    reset_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b1);  // stop, sample, request all ignored in IDLE
    checks++;
    if (dut_vec() !== 43'h0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL idle_ignores got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_prime();
    int starts = 0;
    do_start();
    checks++;
    if (bus.dma_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL prime_plus1 got req=%b busy=%b exp req=0 busy=1", bus.dma_req, busy);
    end
    idle();
    checks++;
    if (bus.dma_req !== 1'b1) begin
      errors++; $display("FAIL prime_dma_plus2 got %b exp 1", bus.dma_req);
    end
    for (int i = 1; i <= 4; i++) feed(32'(i) * 32'h0001_0001);
    checks++;
    if (level !== 5'd4 || bus.dma_req !== 1'b0) begin
      errors++; $display("FAIL prime_block1 got level=%0d req=%b exp level=4 req=0", level, bus.dma_req);
    end
    idle();
    checks++;
    if (bus.dma_req !== 1'b1) begin
      errors++; $display("FAIL prime_dma_second got %b exp 1", bus.dma_req);
    end
    for (int i = 5; i <= 8; i++) feed(32'(i) * 32'h0001_0001);
    for (int i = 0; i < 6; i++) begin
      idle();
      if (bus.i2s_start === 1'b1) starts++;
      if (i == 0) begin
        checks++;
        if (bus.i2s_start !== 1'b1 || level !== 5'd8) begin
          errors++; $display("FAIL prime_start got start=%b level=%0d exp start=1 level=8", bus.i2s_start, level);
        end
      end
    end
    checks++;
    if (starts != 1) begin
      errors++; $display("FAIL prime_start_count got %0d exp 1", starts);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL prime_model got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_serve();
    logic [31:0] want;
    for (int k = 0; k < 3; k++) begin
      repeat (9) idle();
      want = 32'(k + 1) * 32'h0001_0001;
      request();
      checks++;
      if (bus.i2s_valid !== 1'b1 || bus.i2s_data !== want || level !== 5'(7 - k)) begin
        errors++; $display("FAIL serve_%0d got v=%b d=%h lvl=%0d exp v=1 d=%h lvl=%0d",
                           k, bus.i2s_valid, bus.i2s_data, level, want, 7 - k);
      end
      idle();
      checks++;
      if (bus.i2s_valid !== 1'b0 || bus.i2s_data !== want) begin
        errors++; $display("FAIL serve_hold_%0d got v=%b d=%h exp v=0 d=%h", k, bus.i2s_valid, bus.i2s_data, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) feed($urandom());
    for (int i = 0; i < 8; i++) begin
      request();
      checks++;
      if (bus.i2s_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b_%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (level !== 5'd0) begin
      errors++; $display("FAIL b2b_empty got level=%0d exp 0", level);
    end
  endtask

  task automatic test_underrun();
    request();
    checks++;
    if (bus.i2s_valid !== 1'b1 || bus.i2s_data !== 32'h0 || underrun !== 1'b1) begin
      errors++; $display("FAIL underrun_serve got v=%b d=%h u=%b exp v=1 d=0 u=1", bus.i2s_valid, bus.i2s_data, underrun);
    end
    repeat (5) idle();
    checks++;
    if (underrun !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL underrun_sticky got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    logic [31:0] first;
    first = $urandom();
    feed(first);
    for (int i = 1; i < 16; i++) feed($urandom());
    checks++;
    if (level !== 5'd16 || overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_fill got level=%0d ovf=%b exp level=16 ovf=0", level, overflow);
    end
    feed(32'hDEAD_BEEF);
    checks++;
    if (level !== 5'd16 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_drop got level=%0d ovf=%b exp level=16 ovf=1", level, overflow);
    end
    request();
    checks++;
    if (bus.i2s_data !== first || level !== 5'd15 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL overflow_oldest got d=%h lvl=%0d exp d=%h lvl=15", bus.i2s_data, level, first);
    end
  endtask

  // Stop, then keep serving and supplying owed samples until the model is idle.
  task automatic drain(input string tag);
    int n = 0;
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    while (m_state != M_IDLE && n < 200) begin
      cycle(1'b0, 1'b0, m_out, $urandom(), 1'b1);
      n++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL %s_drain cyc %0d got %h exp %h", tag, n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (m_state != M_IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL %s_drain_end got busy=%b after %0d cycles exp busy=0", tag, busy, n);
    end
  endtask

  task automatic test_clear_on_start();
    drain("clear");
    checks++;
    if (underrun !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL flags_idle got u=%b o=%b exp u=1 o=1", underrun, overflow);
    end
    do_start();
    checks++;
    if (underrun !== 1'b0 || overflow !== 1'b0 || level !== 5'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL flags_clear got u=%b o=%b lvl=%0d busy=%b exp 0 0 0 1", underrun, overflow, level, busy);
    end
  endtask

  task automatic test_stop_drain();
    bit dma_seen = 0;
    idle();
    for (int i = 0; i < 4; i++) feed($urandom());
    idle();
    for (int i = 0; i < 4; i++) feed($urandom());
    idle();
    for (int i = 0; i < 2; i++) feed($urandom());
    for (int i = 0; i < 5; i++) request();
    checks++;
    if (level !== 5'd5 || m_out != 1 || m_rx != 2) begin
      errors++; $display("FAIL stop_setup got level=%0d exp 5", level);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    if (bus.dma_req === 1'b1) dma_seen = 1;
    for (int i = 0; i < 2; i++) begin
      feed($urandom());
      if (bus.dma_req === 1'b1) dma_seen = 1;
    end
    for (int i = 0; i < 7; i++) begin
      request();
      if (bus.dma_req === 1'b1) dma_seen = 1;
      checks++;
      if (bus.i2s_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stop_serve_%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (busy !== 1'b1 || level !== 5'd0) begin
      errors++; $display("FAIL stop_last_pop got busy=%b lvl=%0d exp busy=1 lvl=0", busy, level);
    end
    idle();
    checks++;
    if (busy !== 1'b0 || dma_seen) begin
      errors++; $display("FAIL stop_idle got busy=%b dma_seen=%b exp busy=0 dma_seen=0", busy, dma_seen);
    end
  endtask

  task automatic test_reset_mid_run();
    do_start();
    idle();
    for (int i = 0; i < 8; i++) feed($urandom());
    idle();
    request();
    request();
    checks++;
    if (level !== 5'd6 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_setup got level=%0d busy=%b exp 6 1", level, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 43'h0) begin
      errors++; $display("FAIL midrun_async got %h exp %h", dut_vec(), 43'h0);
    end
    model_reset();
    @(negedge in_clk);
    reset_n = 1'b1;
    request();
    checks++;
    if (bus.i2s_valid !== 1'b0 || dut_vec() !== 43'h0) begin
      errors++; $display("FAIL midrun_release got %h exp %h", dut_vec(), 43'h0);
    end
  endtask

  task automatic test_random();
    int p_sv[3]  = '{60, 30, 90};
    int p_req[3] = '{30, 60, 90};
    for (int r = 0; r < 3; r++) begin
      do_start();
      for (int n = 0; n < 300; n++) begin
        cycle($urandom_range(0, 99) < 2, 1'b0,
              $urandom_range(0, 99) < p_sv[r], $urandom(),
              $urandom_range(0, 99) < p_req[r]);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL random_r%0d cyc %0d got %h exp %h", r, n, dut_vec(), exp_vec());
        end
      end
      drain("random");
    end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_data  = 32'h0;
    bus.i2s_req      = 1'b0;
    @(negedge in_clk);
    test_reset();
    test_prime();
    test_serve();
    test_back_to_back();
    test_underrun();
    test_overflow();
    test_clear_on_start();
    test_stop_drain();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
